hawk_cmpdcmp_rd_mngr: RTL and testbench

Upstream stage of the compress/decompress write manager. On a compress request it fetches one 4 KB page as 64 cache lines over an internal AXI read channel, builds a per-line zero bitmap, and decides whether the page is compressible. For compressible pages it presents the iWay/cPage packet and pulses `cmpdcmp_trigger` to the write manager. It then holds that packet stable until `cmpdcmp_done` returns.

---
 rtl/hacd_pkg.sv | 26 ++
 rtl/hawk_cmpdcmp_rd_mngr_if.sv | 21 ++
 rtl/hawk_line_zchk.sv | 31 +++
 rtl/hawk_cmpdcmp_rd_mngr.sv | 153 +++++++++++++++
 tb/tb_hawk_cmpdcmp_rd_mngr.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hacd_pkg.sv
// Shared types and constants for the HAWK compress/decompress datapath.
package hacd_pkg;

    localparam int HAWK_PAGE_LINES   = 64;
    localparam int HAWK_LINE_SHIFT   = 6;
    localparam int HAWK_ZSMD_BMP_LSB = 0;
    localparam int HAWK_ZSMD_NZ_LSB  = 64;
    localparam int HAWK_ZSMD_W       = 400;

    typedef struct packed {
        logic [23:0]            iWay_ptr;
        logic [23:0]            nxtWay_ptr;
        logic [47:0]            cPage_byteStart;
        logic [HAWK_ZSMD_W-1:0] zsPgMd;
    } iWayORcPagePkt_t;

    typedef enum logic [2:0] {
        CMPRD_IDLE,
        CMPRD_FETCH,
        CMPRD_DECIDE,
        CMPRD_TRIGGER,
        CMPRD_WAIT_DONE,
        CMPRD_RESP
    } hawk_cmprd_state_e;

endpackage

// File: rtl/hawk_cmpdcmp_rd_mngr_if.sv
// Internal line-read channel between the read manager and the page fetch port.
interface hawk_cmpdcmp_rd_mngr_if;

    logic         rd_req_valid;
    logic         rd_req_ready;
    logic [47:0]  rd_req_addr;
    logic         rd_rsp_valid;
    logic [511:0] rd_rsp_data;
    logic         rd_rsp_ready;

    modport master (
        output rd_req_valid, rd_req_addr, rd_rsp_ready,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_rsp_ready,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data
    );

endinterface

// File: rtl/hawk_line_zchk.sv
// One-stage registered zero detect on a read beat; the line index travels with it.
module hawk_line_zchk #(
    parameter int DATA_W = 512,
    parameter int IDX_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    output logic              out_zero,
    output logic [IDX_W-1:0]  out_idx
);

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
            out_zero  <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_zero <= (in_data == '0);
                out_idx  <= in_idx;
            end
        end
    end

endmodule

// File: rtl/hawk_cmpdcmp_rd_mngr.sv
// Fetches a page line by line, builds its zero bitmap and hands compressible
// pages to the write manager as an iWay/cPage packet.
module hawk_cmpdcmp_rd_mngr
    import hacd_pkg::*;
#(
    parameter int PAGE_LINES = HAWK_PAGE_LINES,
    parameter int MAX_OUT    = 4,
    parameter int NZ_THRESH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmp_req,
    input  logic [47:0]           cmp_page_addr,
    input  logic [23:0]           cmp_iway_ptr,
    input  logic [23:0]           cmp_nxtway_ptr,
    input  logic [47:0]           cmp_cpage_byte_start,
    output logic                  cmp_busy,
    output logic                  cmp_resp_valid,
    output logic                  cmp_resp_compressed,
    hawk_cmpdcmp_rd_mngr_if.master rd,
    output logic                  cmpdcmp_trigger,
    output iWayORcPagePkt_t       iWayORcPagePkt,
    input  logic                  cmpdcmp_done
);

    localparam int CNT_W = $clog2(PAGE_LINES) + 1;
    localparam int IDX_W = $clog2(PAGE_LINES);
    localparam logic [CNT_W-1:0] LINES_C = CNT_W'(PAGE_LINES);
    localparam logic [CNT_W-1:0] MAXO_C  = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] THR_C   = CNT_W'(NZ_THRESH);

    hawk_cmprd_state_e state_q, state_d;

    logic [CNT_W-1:0]       req_cnt_q, rsp_cnt_q, rsp_cnt_d, nz_cnt_q, nz_cnt_d, outstanding;
    logic [PAGE_LINES-1:0]  zero_bmp_q, zero_bmp_d;
    logic [HAWK_ZSMD_W-1:0] zsmd_d;
    logic [47:0]            page_addr_q, cpage_q;
    logic [23:0]            iway_q, nxtway_q;
    logic                   comp_q;
    iWayORcPagePkt_t        pkt_q;

    logic             start, fetch, req_hs, beat_acc;
    logic             zc_valid, zc_zero;
    logic [IDX_W-1:0] zc_idx;

    assign start       = (state_q == CMPRD_IDLE) && cmp_req;
    assign fetch       = (state_q == CMPRD_FETCH);
    assign outstanding = req_cnt_q - rsp_cnt_q;

    assign rd.rd_req_valid = fetch && (req_cnt_q < LINES_C) && (outstanding < MAXO_C);
    assign rd.rd_req_addr  = rd.rd_req_valid
                           ? page_addr_q + (48'(req_cnt_q) << HAWK_LINE_SHIFT) : '0;
    assign rd.rd_rsp_ready = 1'b1;
    assign req_hs          = rd.rd_req_valid && rd.rd_req_ready;
    // Beats outside FETCH are dropped before they reach the counters or the detector.
    assign beat_acc        = fetch && rd.rd_rsp_valid;

    hawk_line_zchk #(
        .DATA_W (512),
        .IDX_W  (IDX_W)
    ) u_zchk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (beat_acc),
        .in_data   (rd.rd_rsp_data),
        .in_idx    (rsp_cnt_q[IDX_W-1:0]),
        .out_valid (zc_valid),
        .out_zero  (zc_zero),
        .out_idx   (zc_idx)
    );

    // Next-value view of the bitmap and count, so DECIDE sees the pipelined last beat.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        zero_bmp_d = zero_bmp_q;
        nz_cnt_d   = nz_cnt_q;
        rsp_cnt_d  = rsp_cnt_q + CNT_W'(beat_acc);
        zsmd_d     = '0;
        if (zc_valid) begin
            zero_bmp_d[zc_idx] = zc_zero;
            if (!zc_zero && (nz_cnt_q != LINES_C)) nz_cnt_d = nz_cnt_q + CNT_W'(1);
        end
        zsmd_d[HAWK_ZSMD_BMP_LSB +: PAGE_LINES] = zero_bmp_d;
        zsmd_d[HAWK_ZSMD_NZ_LSB  +: CNT_W]      = nz_cnt_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CMPRD_IDLE:      if (cmp_req) state_d = CMPRD_FETCH;
            CMPRD_FETCH:     if (rsp_cnt_d == LINES_C) state_d = CMPRD_DECIDE;
            CMPRD_DECIDE:    state_d = (nz_cnt_d <= THR_C) ? CMPRD_TRIGGER : CMPRD_RESP;
            CMPRD_TRIGGER:   state_d = CMPRD_WAIT_DONE;
            CMPRD_WAIT_DONE: if (cmpdcmp_done) state_d = CMPRD_RESP;
            CMPRD_RESP:      state_d = CMPRD_IDLE;
            default:         state_d = CMPRD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= CMPRD_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            nz_cnt_q    <= '0;
            zero_bmp_q  <= '0;
            page_addr_q <= '0;
            cpage_q     <= '0;
            iway_q      <= '0;
            nxtway_q    <= '0;
            comp_q      <= 1'b0;
            pkt_q       <= '0;
        end else begin
            if (start) begin
                page_addr_q <= cmp_page_addr;
                cpage_q     <= cmp_cpage_byte_start;
                iway_q      <= cmp_iway_ptr;
                nxtway_q    <= cmp_nxtway_ptr;
                req_cnt_q   <= '0;
                rsp_cnt_q   <= '0;
                nz_cnt_q    <= '0;
                zero_bmp_q  <= '0;
                comp_q      <= 1'b0;
            end else begin
                if (req_hs) req_cnt_q <= req_cnt_q + CNT_W'(1);
                rsp_cnt_q  <= rsp_cnt_d;
                nz_cnt_q   <= nz_cnt_d;
                zero_bmp_q <= zero_bmp_d;
            end
            if (state_q == CMPRD_DECIDE) comp_q <= (state_d == CMPRD_TRIGGER);
            // Packet is live from TRIGGER through the last WAIT_DONE cycle, zero otherwise.
            if ((state_q == CMPRD_DECIDE) && (state_d == CMPRD_TRIGGER)) begin
                pkt_q.iWay_ptr        <= iway_q;
                pkt_q.nxtWay_ptr      <= nxtway_q;
                pkt_q.cPage_byteStart <= cpage_q;
                pkt_q.zsPgMd          <= zsmd_d;
            end else if ((state_q == CMPRD_WAIT_DONE) && (state_d != CMPRD_WAIT_DONE)) begin
                pkt_q <= '0;
            end
        end
    end

    assign cmp_busy            = (state_q != CMPRD_IDLE);
    assign cmp_resp_valid      = (state_q == CMPRD_RESP);
    assign cmp_resp_compressed = (state_q == CMPRD_RESP) && comp_q;
    assign cmpdcmp_trigger     = (state_q == CMPRD_TRIGGER);
    assign iWayORcPagePkt      = pkt_q;

endmodule

// File: tb/tb_hawk_cmpdcmp_rd_mngr.sv
// Directed bench: table of page patterns with hand-computed bitmap/count and
// timing expectations, plus reset-abort and stray-beat sequences.
module tb_hawk_cmpdcmp_rd_mngr;
    import hacd_pkg::*;

    localparam int LINES = 64;
    localparam int MAXO  = 4;
    localparam int THR   = 32;

    typedef struct {
        logic [63:0] nz_mask;
        int          rsp_delay;
        bit          rnd_ready;
        int          done_delay;
        bit          stray;
        bit          idle_beat;
        bit          exp_trig;
        logic [6:0]  exp_nz;
        logic [63:0] exp_bmp;
        logic [47:0] page;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic cmp_req, cmpdcmp_done;
    logic [47:0] cmp_page_addr, cmp_cpage_byte_start;
    logic [23:0] cmp_iway_ptr, cmp_nxtway_ptr;
    logic cmp_busy, cmp_resp_valid, cmp_resp_compressed, cmpdcmp_trigger;
    iWayORcPagePkt_t pkt;

    hawk_cmpdcmp_rd_mngr_if rd_if ();

    hawk_cmpdcmp_rd_mngr #(
        .PAGE_LINES (LINES),
        .MAX_OUT    (MAXO),
        .NZ_THRESH  (THR)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .cmp_req              (cmp_req),
        .cmp_page_addr        (cmp_page_addr),
        .cmp_iway_ptr         (cmp_iway_ptr),
        .cmp_nxtway_ptr       (cmp_nxtway_ptr),
        .cmp_cpage_byte_start (cmp_cpage_byte_start),
        .cmp_busy             (cmp_busy),
        .cmp_resp_valid       (cmp_resp_valid),
        .cmp_resp_compressed  (cmp_resp_compressed),
        .rd                   (rd_if),
        .cmpdcmp_trigger      (cmpdcmp_trigger),
        .iWayORcPagePkt       (pkt),
        .cmpdcmp_done         (cmpdcmp_done)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] line_data(input int idx, input logic nz);
        logic [511:0] d;
        d = '0;
        if (nz) d[(idx * 37) % 512] = 1'b1;
        return d;
    endfunction

    // Results of the most recent operation
    int n_req, n_rsp, n_trig, n_resp, trig_cyc, done_cyc, resp_cyc, last_beat, idle_cyc;
    int max_out, addr_err, valid_err, pkt_err;
    logic v1, resp_comp, timed_out;
    iWayORcPagePkt_t trig_pkt;
    logic [47:0] cur_page, cur_cpage;
    logic [23:0] cur_iway, cur_nxtway;

    task automatic run_op(input vec_t v, input int abort_at);
        int q[$];
        int cyc, outst;
        bit trig_seen, exp_valid;
        iWayORcPagePkt_t exp_pkt;
        n_req = 0; n_rsp = 0; n_trig = 0; n_resp = 0;
        trig_cyc = -1; done_cyc = -1; resp_cyc = -1; last_beat = -1; idle_cyc = -1;
        max_out = 0; addr_err = 0; valid_err = 0; pkt_err = 0;
        v1 = 1'b0; resp_comp = 1'b0; timed_out = 1'b0; trig_pkt = '0; trig_seen = 1'b0;
        cur_page   = v.page;
        cur_iway   = v.page[35:12];
        cur_nxtway = ~v.page[35:12];
        cur_cpage  = v.page + 48'h0000_8000_0000;
        @(negedge clk_i);
        cmp_req              = 1'b1;
        cmp_page_addr        = cur_page;
        cmp_iway_ptr         = cur_iway;
        cmp_nxtway_ptr       = cur_nxtway;
        cmp_cpage_byte_start = cur_cpage;
        if (v.idle_beat) begin
            rd_if.rd_rsp_valid = 1'b1;
            rd_if.rd_rsp_data  = {16{32'hFFFF_0001}};
        end
        cyc = 0;
        while (1) begin
            @(negedge clk_i);
            cyc++;
            cmp_req            = 1'b0;
            cmpdcmp_done       = 1'b0;
            rd_if.rd_rsp_valid = 1'b0;
            rd_if.rd_rsp_data  = {16{32'hDEAD_BEEF}};
            if (cyc == 1) v1 = rd_if.rd_req_valid;
            if (!cmp_busy) begin idle_cyc = cyc; break; end
            if (cyc > 2000) begin timed_out = 1'b1; break; end
            if (abort_at > 0 && n_rsp == abort_at) break;
            outst     = n_req - n_rsp;
            exp_valid = (n_rsp < LINES) && (n_req < LINES) && (outst < MAXO);
            if (rd_if.rd_req_valid !== exp_valid) valid_err++;
            if (outst > max_out) max_out = outst;
            rd_if.rd_req_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_if.rd_req_valid && rd_if.rd_req_ready) begin
                if (rd_if.rd_req_addr !== v.page + 48'(n_req * 64)) addr_err++;
                q.push_back(cyc + v.rsp_delay);
                n_req++;
            end
            if (q.size() > 0 && q[0] <= cyc) begin
                void'(q.pop_front());
                rd_if.rd_rsp_valid = 1'b1;
                rd_if.rd_rsp_data  = line_data(n_rsp, v.nz_mask[n_rsp]);
                n_rsp++;
                if (n_rsp == LINES) last_beat = cyc;
            end
            if (cmpdcmp_trigger) begin
                n_trig++; trig_cyc = cyc; trig_pkt = pkt; trig_seen = 1'b1;
            end
            exp_pkt = (trig_seen && (done_cyc < 0 || cyc <= done_cyc)) ? trig_pkt : '0;
            if (pkt !== exp_pkt) pkt_err++;
            if (trig_seen && cyc == trig_cyc + v.done_delay) begin
                cmpdcmp_done = 1'b1; done_cyc = cyc;
            end
            if (v.stray && cyc == 5) begin
                cmp_req              = 1'b1;
                cmp_page_addr        = v.page ^ 48'h0000_00F0_0000;
                cmp_iway_ptr         = ~cur_iway;
                cmp_nxtway_ptr       = cur_iway;
                cmp_cpage_byte_start = 48'h0;
                cmpdcmp_done         = 1'b1;
            end
            if (cmp_resp_valid) begin
                n_resp++; resp_cyc = cyc; resp_comp = cmp_resp_compressed;
            end
        end
        cmp_req            = 1'b0;
        cmpdcmp_done       = 1'b0;
        rd_if.rd_rsp_valid = 1'b0;
        rd_if.rd_req_ready = 1'b0;
    endtask

    task automatic check_op(input vec_t v, input string nm);
        check({nm, "_timeout"}, timed_out, 1'b0);
        check({nm, "_valid_t1"}, v1, 1'b1);
        check({nm, "_addr_order"}, addr_err, 0);
        check({nm, "_n_req"}, n_req, LINES);
        check({nm, "_issue_rule"}, valid_err, 0);
        check({nm, "_max_out_ok"}, max_out <= MAXO, 1'b1);
        check({nm, "_n_trig"}, n_trig, v.exp_trig);
        check({nm, "_n_resp"}, n_resp, 1);
        check({nm, "_compressed"}, resp_comp, v.exp_trig);
        check({nm, "_busy_low"}, idle_cyc, resp_cyc + 1);
        check({nm, "_pkt_window"}, pkt_err, 0);
        if (v.exp_trig) begin
            check({nm, "_trig_lat"}, trig_cyc, last_beat + 2);
            check({nm, "_resp_lat"}, resp_cyc, done_cyc + 1);
            check({nm, "_bmp"}, trig_pkt.zsPgMd[63:0], v.exp_bmp);
            check({nm, "_nz"}, trig_pkt.zsPgMd[70:64], v.exp_nz);
            check({nm, "_zsmd_hi"}, trig_pkt.zsPgMd[399:71], 0);
            check({nm, "_iway"}, trig_pkt.iWay_ptr, cur_iway);
            check({nm, "_nxtway"}, trig_pkt.nxtWay_ptr, cur_nxtway);
            check({nm, "_cpage"}, trig_pkt.cPage_byteStart, cur_cpage);
        end else begin
            check({nm, "_resp_lat"}, resp_cyc, last_beat + 2);
        end
        if (v.rsp_delay == 1 && !v.rnd_ready) check({nm, "_fetch_len"}, last_beat, LINES + 1);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_busy"}, cmp_busy, 1'b0);
        check({nm, "_req_valid"}, rd_if.rd_req_valid, 1'b0);
        check({nm, "_req_addr"}, rd_if.rd_req_addr, 48'h0);
        check({nm, "_rsp_ready"}, rd_if.rd_rsp_ready, 1'b1);
        check({nm, "_trigger"}, cmpdcmp_trigger, 1'b0);
        check({nm, "_resp_valid"}, cmp_resp_valid, 1'b0);
        check({nm, "_resp_comp"}, cmp_resp_compressed, 1'b0);
        check({nm, "_pkt"}, pkt, '0);
    endtask

    vec_t vecs[6];
    vec_t rv, pv;
    int quiet_err;

    initial begin
        //               nz_mask                dly rnd dd st ib trg nz  exp_bmp                page
        vecs[0] = '{64'h0000_0000_0000_0000, 1, 0, 3, 0, 0, 1, 7'd0,  64'hFFFF_FFFF_FFFF_FFFF, 48'h0000_1234_5000};
        vecs[1] = '{64'h0000_0001_FFFF_FFFF, 1, 0, 1, 0, 0, 0, 7'd33, 64'hFFFF_FFFE_0000_0000, 48'h0000_0ABC_D000};
        vecs[2] = '{64'h0000_0000_FFFF_FFFF, 1, 0, 5, 0, 0, 1, 7'd32, 64'hFFFF_FFFF_0000_0000, 48'h0042_0000_1000};
        vecs[3] = '{64'hAAAA_AAAA_AAAA_AAAA, 10, 1, 2, 1, 0, 1, 7'd32, 64'h5555_5555_5555_5555, 48'h0000_7777_0000};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 3, 1, 1, 0, 0, 0, 7'd64, 64'h0000_0000_0000_0000, 48'h0001_0000_0000};
        vecs[5] = '{64'h8000_0000_0000_0001, 2, 0, 1, 0, 1, 1, 7'd2,  64'h7FFF_FFFF_FFFF_FFFE, 48'h0000_0000_F000};
        rv      = '{64'h00FF_00FF_00FF_00FF, 2, 0, 1, 0, 0, 0, 7'd0,  64'h0,                   48'h0000_5555_A000};
        pv      = '{64'h0000_0000_0000_0000, 1, 0, 2, 0, 1, 1, 7'd0,  64'hFFFF_FFFF_FFFF_FFFF, 48'h0000_9999_3000};

        rst_i                = 1'b1;
        cmp_req              = 1'b0;
        cmpdcmp_done         = 1'b0;
        cmp_page_addr        = '0;
        cmp_iway_ptr         = '0;
        cmp_nxtway_ptr       = '0;
        cmp_cpage_byte_start = '0;
        rd_if.rd_req_ready   = 1'b0;
        rd_if.rd_rsp_valid   = 1'b0;
        rd_if.rd_rsp_data    = '0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("por");
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) check_op_wrap(i);

        // Abort after 20 beats, then stray beats while idle, then a clean page
        run_op(rv, 20);
        check("abort_n_rsp", n_rsp, 20);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk_i);
        rst_i     = 1'b0;
        quiet_err = 0;
        for (int k = 0; k < 4; k++) begin
            rd_if.rd_rsp_valid = 1'b1;
            rd_if.rd_rsp_data  = line_data(k, 1'b1);
            @(negedge clk_i);
            if (cmp_busy !== 1'b0 || cmp_resp_valid !== 1'b0 || cmpdcmp_trigger !== 1'b0) quiet_err++;
        end
        rd_if.rd_rsp_valid = 1'b0;
        check("idle_beats_quiet", quiet_err, 0);
        run_op(pv, 0);
        check_op(pv, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic check_op_wrap(input int i);
        run_op(vecs[i], 0);
        check_op(vecs[i], $sformatf("vec%0d", i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
